// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit load/store into two 16-bit asynchronous SRAM accesses
// with WAIT_CYCLES clocks per half-word, stalling the pipeline through ready.
module sram_controller #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    state_t      state, state_n;
    logic        op_wr;
    logic [16:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt;
    logic [16:0] word_off;
    logic        last, phase, drive;
    assign word_off = 17'((address - ADDR_BASE) >> 2);
    assign last     = cnt == 4'(WAIT_CYCLES - 1);
    assign phase    = state == LOW || state == HIGH;
    assign drive    = op_wr && phase;
    assign ready    = ~(rd_en | wr_en) | (state == DONE);
    assign SRAM_WE_N = ~drive;
    assign SRAM_ADDR = {addr_q, state == HIGH};
    assign SRAM_DQ   = drive ? (state == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (rd_en | wr_en) ? LOW : IDLE;
            LOW:     state_n = last ? HIGH : LOW;
            HIGH:    state_n = last ? DONE : HIGH;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            read_data <= 32'd0;
            op_wr     <= 1'b0;
            addr_q    <= 17'd0;
            wdata_q   <= 32'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && (rd_en | wr_en)) begin
                op_wr   <= wr_en;
                addr_q  <= word_off;
                wdata_q <= write_data;
                cnt     <= 4'd0;
            end
            if (phase) begin
                cnt <= last ? 4'd0 : cnt + 4'd1;
                // the SRAM guarantees valid read data only by the final cycle of a phase
                if (last && !op_wr && state == LOW) read_data[15:0] <= SRAM_DQ;
                if (last && !op_wr && state == HIGH) read_data[31:16] <= SRAM_DQ;
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and random loads/stores against a behavioural SRAM and a
// word-level reference memory.
module tb_sram_controller;
    localparam int          W    = 3;
    localparam logic [31:0] BASE = 32'd1024;
    logic        clk, rst, rd_en, wr_en, ready, SRAM_WE_N;
    logic [31:0] address, write_data, read_data;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic [15:0] mem [0:262143];
    logic [15:0] rd_word;
    logic [31:0] ref_mem [logic [16:0]];
    logic [16:0] written [$];
    logic [31:0] last_read = 32'd0;
    logic [17:0] lo_seen, hi_seen;
    int vectors = 0;
    int miscompares = 0;

    sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // asynchronous SRAM with output enable tied active: drives the bus whenever not written
    assign rd_word = mem[SRAM_ADDR];
    assign SRAM_DQ = SRAM_WE_N ? rd_word : 16'bz;
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit chain, input bit hold, input bit perturb, input int rst_at);
        logic [31:0] off = a - BASE;
        logic [16:0] idx = off[18:2];
        int n_rdy0 = 0;
        int n_we0 = 0;
        int n_abad = 0;
        logic done_rdy = 1'b0;
        logic [31:0] done_rd = 32'd0;
        logic [31:0] exp_rd;
        exp_rd = (r && !w && ref_mem.exists(idx)) ? ref_mem[idx] : last_read;
        if (!chain) begin
            @(posedge clk);
            #1;
        end
        wr_en = w;
        rd_en = r;
        address = a;
        write_data = d;
        for (int i = 0; i <= 2 * W + 1; i++) begin
            @(negedge clk);
            if (!ready) n_rdy0++;
            if (!SRAM_WE_N) n_we0++;
            if (i >= 1 && i <= 2 * W && SRAM_ADDR !== {idx, 1'(i > W)}) n_abad++;
            if (i == 1) lo_seen = SRAM_ADDR;
            if (i == W + 1) hi_seen = SRAM_ADDR;
            if (i == 2 * W + 1) begin
                done_rdy = ready;
                done_rd = read_data;
            end
            if (perturb && i == 2) begin
                address = $urandom;
                write_data = $urandom;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                wr_en = 1'b0;
                rd_en = 1'b0;
                @(negedge clk);
                chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
                chk("rst_ready", 32'(ready), 32'd1);
                chk("rst_read_data", read_data, 32'd0);
                chk("rst_dq_released", 32'(SRAM_DQ), 32'(rd_word));
                last_read = 32'd0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
        chk("stall_cycles", n_rdy0, 2 * W + 1);
        chk("done_ready", 32'(done_rdy), 32'd1);
        chk("we_low_cycles", n_we0, w ? 2 * W : 0);
        chk("addr_errors", n_abad, 0);
        chk("read_data", done_rd, exp_rd);
        if (w) begin
            ref_mem[idx] = d;
            written.push_back(idx);
        end else last_read = exp_rd;
    endtask

    initial begin
        int bad;
        logic [16:0] ridx;
        logic [31:0] o;
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("reset_sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ !== rd_word) bad++;
        end
        chk("idle_activity", bad, 0);
        txn(1, 0, 32'd1028, 32'hDEADBEEF, 0, 0, 0, -1);
        chk("store_mem2", 32'(mem[2]), 32'h0000BEEF);
        chk("store_mem3", 32'(mem[3]), 32'h0000DEAD);
        txn(0, 1, 32'd1028, 32'd0, 0, 0, 0, -1);
        txn(1, 1, 32'd1024, 32'h12345678, 0, 0, 1, -1);
        chk("prio_mem0", 32'(mem[0]), 32'h00005678);
        chk("prio_mem1", 32'(mem[1]), 32'h00001234);
        txn(0, 1, 32'd1024, 32'd0, 0, 1, 0, -1);
        txn(0, 1, 32'd1028, 32'd0, 1, 0, 0, -1);
        txn(1, 0, BASE + 32'h7FFFC, 32'hA5A55A5A, 0, 0, 0, -1);
        chk("bound_addr_lo", 32'(lo_seen), 32'h3FFFE);
        chk("bound_addr_hi", 32'(hi_seen), 32'h3FFFF);
        txn(0, 1, BASE + 32'h7FFFC, 32'd0, 0, 0, 0, -1);
        chk("bound_read_addr_hi", 32'(hi_seen), 32'h3FFFF);
        txn(1, 0, BASE + 32'h100, 32'hCAFEF00D, 0, 0, 0, W + 2);
        txn(1, 0, BASE + 32'h100, 32'h0BADC0DE, 0, 0, 0, -1);
        txn(0, 1, BASE + 32'h100, 32'd0, 0, 0, 0, -1);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                o = {13'($urandom), 17'($urandom), 2'($urandom)};
                txn(1, 1'($urandom_range(0, 1)), o + BASE, $urandom, 0, 0, 0, -1);
            end else begin
                ridx = written[$urandom_range(0, written.size() - 1)];
                o = {13'($urandom), ridx, 2'($urandom)};
                txn(0, 1, o + BASE, $urandom, 0, 0, 1'($urandom_range(0, 1)), -1);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
